// File: rtl/score_bcd_counter_pkg.sv
// Shared types and constants for the serial BCD score counter.
package score_bcd_counter_pkg;

  localparam int          NUM_DIGITS    = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic        OP_ADD        = 1'b0;
  localparam logic        OP_SUB        = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/score_bcd_counter_bcd_digit_step.sv
// One BCD digit add/subtract step with a 0..9 carry/borrow in and a 1-bit carry/borrow out.
module bcd_digit_step
  import score_bcd_counter_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic [3:0] cin_i,
  input  logic       op_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [4:0] sum;

  always_comb begin
    sum     = {1'b0, digit_i} + {1'b0, cin_i};
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (op_i == OP_ADD) begin
      if (sum > 5'd9) begin
        digit_o = 4'(sum - 5'd10);
        cout_o  = 1'b1;
      end else begin
        digit_o = sum[3:0];
      end
    end else begin
      // Modulo-16 arithmetic is exact here: the true result is always 0..9.
      if (digit_i < cin_i) begin
        digit_o = digit_i + 4'd10 - cin_i;
        cout_o  = 1'b1;
      end else begin
        digit_o = digit_i - cin_i;
      end
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Four-digit BCD score register, updated serially one digit per cycle.
// Define SCORE_WRAP_EN to wrap modulo 10000 instead of saturating.
module score_bcd_counter
  import score_bcd_counter_pkg::*;
#(
  parameter logic [15:0] RESET_SCORE = 16'h0000,
  parameter int          MAX_STEP    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [3:0] cmd_val,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic       sat
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_e                           state_q, state_d;
  logic                             op_q, op_d;
  logic [NUM_DIGITS-1:0][3:0]       work_q, work_d;
  logic [NUM_DIGITS-1:0][3:0]       digits_q, digits_d;
  logic [3:0]                       carry_q, carry_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             sat_q, sat_d;

  logic [3:0] step_val;
  logic [3:0] step_digit;
  logic       step_cout;

  assign step_val = (cmd_val > 4'(MAX_STEP)) ? 4'(MAX_STEP) : cmd_val;

  bcd_digit_step u_step (
    .digit_i (work_q[idx_q]),
    .cin_i   (carry_q),
    .op_i    (op_q),
    .digit_o (step_digit),
    .cout_o  (step_cout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    digits_d  = digits_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sat_d     = 1'b0;
    cmd_ready = (state_q == ST_IDLE) && !clr;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          work_d  = digits_q;
          carry_d = step_val;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        work_d[idx_q] = step_digit;
        carry_d       = {3'b000, step_cout};
        idx_d         = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        sat_d   = (carry_q != 4'd0);
        state_d = ST_IDLE;
`ifdef SCORE_WRAP_EN
        digits_d = work_q;
`else
        if (carry_q != 4'd0) begin
          digits_d = (op_q == OP_ADD) ? {NUM_DIGITS{BCD_MAX_DIGIT}} : '0;
        end else begin
          digits_d = work_q;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear discards any in-flight command; the display never sees work.
    if (clr) begin
      digits_d = RESET_SCORE;
      state_d  = ST_IDLE;
      sat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      work_q   <= '0;
      digits_q <= RESET_SCORE;
      carry_q  <= '0;
      idx_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      digits_q <= digits_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sat_q    <= sat_d;
    end
  end

  assign digit_1 = digits_q[3];
  assign digit_2 = digits_q[2];
  assign digit_3 = digits_q[1];
  assign digit_4 = digits_q[0];
  assign sat     = sat_q;

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Producer side of the four-digit seven-segment display interface.
- Holds the game score as four BCD digits and applies add/subtract commands through a valid/ready handshake.
- Drives digit_1..digit_4 directly into the display multiplexer: digit_1 is thousands, digit_4 is units.
- Arithmetic runs serially, one digit per cycle, with a ripple carry/borrow. Result saturates at 9999/0000.

Parameters:
- RESET_SCORE, 16'h0000, packed BCD value loaded on reset and on clr; must be valid BCD; [15:12] maps to digit_1.
- MAX_STEP, 9, largest accepted cmd_val; larger values are clamped to MAX_STEP; must be 1..9.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  synchronous score clear to RESET_SCORE.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  1  0 = add, 1 = subtract.
- cmd_val  in  4  step magnitude, binary 0..15, clamped to MAX_STEP.
- digit_1  out  4  thousands BCD digit.
- digit_2  out  4  hundreds BCD digit.
- digit_3  out  4  tens BCD digit.
- digit_4  out  4  units BCD digit.
- sat  out  1  one-cycle pulse on commit when the result saturated.

Behaviour:
- Reset (rst_n=0 at posedge):
  - digits = RESET_SCORE, sat = 0, state = IDLE, cmd_ready = 1 after the edge.
  - Reset overrides clr and any command.
- States: IDLE, CALC, COMMIT.
  - IDLE: cmd_ready = 1. At edge N with cmd_valid=1:
    - latch op;
    - work = digit outputs;
    - carry/borrow register = min(cmd_val, MAX_STEP);
    - idx = 0;
    - go to CALC.
  - CALC: at edges N+1..N+4, process work digit idx (0 = units).
    - Add: s = d + c; if s > 9 then d = s - 10, c = 1; else d = s, c = 0.
    - Subtract: s = d - c; if s < 0 then d = s + 10, c = 1; else d = s, c = 0.
    - After idx = 3, go to COMMIT.
  - COMMIT: at edge N+5:
    - If c = 0, digits = work.
    - If c = 1 (overflow on add, underflow on subtract), digits = 9999 for add or 0000 for subtract, and sat = 1 for this cycle only.
    - Go to IDLE.
- Timing:
  - Digit outputs change only at the COMMIT edge and are stable during CALC. The display never shows partial results.
  - Latency: accept at edge N, new digits visible after edge N+5. Next accept is possible at edge N+6.
  - cmd_val = 0 is a legal no-op: it runs the full sequence and sat stays 0.
- Handshake:
  - cmd_ready is combinational: state == IDLE && !clr.
  - A command is consumed only when cmd_valid && cmd_ready at a posedge.
  - cmd_valid while busy is ignored, not queued.
  - cmd_op and cmd_val are sampled only at the accept edge.
- clr:
  - At any posedge with rst_n = 1 and clr = 1: digits = RESET_SCORE, in-flight command discarded, state = IDLE, sat = 0.
  - clr with a simultaneous cmd_valid: the command is not accepted, since cmd_ready = 0.
- Boundaries:
  - 9999 + 1 saturates to 9999 with a sat pulse.
  - 0000 - 1 saturates to 0000 with a sat pulse.
  - 0995 + 5 gives 1000; the carry ripples through three digits.
  - A result of exactly 9999 or 0000 without carry does not pulse sat.
- Digit registers always hold valid BCD (0..9).

Optional Feature:
- Macro: SCORE_WRAP_EN.
- Defined: no saturation. COMMIT always writes work, so results wrap modulo 10000 (9999+1 = 0000, 0000-1 = 9999). sat pulses on every wrap (final c = 1), acting as a wrap indicator.
- Undefined: saturating behaviour as specified above.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/CALC/COMMIT, 2 bits);
  - OP_ADD/OP_SUB constants;
  - BCD_MAX_DIGIT = 9;
  - NUM_DIGITS = 4.
- One natural sub-module: bcd_digit_step.
  - Combinational.
  - Inputs: digit, carry-in value (0..9), op.
  - Outputs: result digit, carry-out.
  - Instantiated once; the FSM feeds it the indexed work digit.

Test Plan:
- Reset with RESET_SCORE = 16'h0000, then add 7 -> cmd_ready low for 5 cycles; digits 0,0,0,7 after edge N+5; sat = 0.
- Score 0995, add 5 -> digits 1,0,0,0 at N+5; no intermediate digit change at N+1..N+4.
- Score 9998, add 9 -> 9999 and a single-cycle sat pulse. With SCORE_WRAP_EN -> 0007 and sat pulse.
- Score 0003, subtract 5 -> 0000 and sat pulse. With SCORE_WRAP_EN -> 9998.
- Accept add 4 at score 0010, then assert clr at N+2 -> digits = RESET_SCORE, no commit, no sat; cmd_ready high after clr deasserts.
- cmd_valid held high continuously with cmd_val = 15 -> accepts every 6 cycles, each adds 9 (clamped); back-to-back ordering is correct and commands offered while busy are dropped.
